// File: rtl/uart_rx_unit.sv
// UART receiver for 8N1-style frames with a built-in 16x oversampling baud tick generator.
// Each received byte is presented on rx_dout together with a one-cycle rx_done_tick strobe.
module uart_rx_unit #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int BITS    = 11
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            enable,
  input  logic [BITS-1:0] final_value,
  output logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] rx_dout
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
  localparam logic [3:0]    SB_LAST = 4'(SB_TICK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [BITS-1:0] q_r;
  logic            sync1_r;
  logic            rx_s;
  state_t          state_r, state_nx;
  logic [3:0]      s_r, s_nx;
  logic [NW-1:0]   n_r, n_nx;
  logic [DBIT-1:0] b_r, b_nx;
  logic [DBIT-1:0] dout_r, dout_nx;
  logic            done_r, done_nx;

  // Baud counter; lowering final_value below q lets it run through the full 2^BITS wrap.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      q_r <= '0;
    end else if (enable) begin
      if (q_r == final_value) begin
        q_r <= '0;
      end else begin
        q_r <= q_r + BITS'(1);
      end
    end else begin
      q_r <= q_r;
    end
  end

  assign s_tick = enable && (q_r == final_value);

  // Two-flop synchronizer for the asynchronous rx pin, idling high.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= rx;
      rx_s    <= sync1_r;
    end
  end

  // Receiver state, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_r <= IDLE;
      s_r     <= 4'd0;
      n_r     <= '0;
      b_r     <= '0;
      dout_r  <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      s_r     <= s_nx;
      n_r     <= n_nx;
      b_r     <= b_nx;
      dout_r  <= dout_nx;
      done_r  <= done_nx;
    end
  end

  // Next-state logic: the FSM only advances on oversampling ticks once a frame has started.
  always_comb begin
    state_nx = state_r;
    s_nx     = s_r;
    n_nx     = n_r;
    b_nx     = b_r;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          s_nx     = 4'd0;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_r == 4'd7) begin
            if (!rx_s) begin
              state_nx = DATA;
              s_nx     = 4'd0;
              n_nx     = '0;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            s_nx = s_r + 4'd1;
          end
        end else begin
          s_nx = s_r;
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_r == 4'd15) begin
            s_nx = 4'd0;
            b_nx = {rx_s, b_r[DBIT-1:1]};
            if (n_r == N_LAST) begin
              state_nx = STOP;
            end else begin
              n_nx = n_r + NW'(1);
            end
          end else begin
            s_nx = s_r + 4'd1;
          end
        end else begin
          s_nx = s_r;
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_r == SB_LAST) begin
            state_nx = IDLE;
          end else begin
            s_nx = s_r + 4'd1;
          end
        end else begin
          s_nx = s_r;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Output logic: the byte is published only when the stop bit completes, never mid-shift.
  always_comb begin
    done_nx = 1'b0;
    dout_nx = dout_r;
    case (state_r)
      STOP: begin
        if (s_tick && (s_r == SB_LAST)) begin
          done_nx = 1'b1;
          dout_nx = b_r;
        end else begin
          done_nx = 1'b0;
        end
      end
      default: begin
        done_nx = 1'b0;
      end
    endcase
  end

  assign rx_done_tick = done_r;
  assign rx_dout      = dout_r;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit: tick generator timing, frame reception, glitch rejection,
// mid-frame reset and an unchecked low stop bit.
module tb_uart_rx_unit;

  localparam int BIT_CLK = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx;
  logic        enable;
  logic [10:0] final_value;
  logic        s_tick;
  logic        rx_done_tick;
  logic [7:0]  rx_dout;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int strobes = 0;
  int bad_changes = 0;
  logic [7:0] got_q[$];
  logic [7:0] prev_dout = 8'h00;

  uart_rx_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .enable       (enable),
    .final_value  (final_value),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge; rx_dout may only move together with a strobe.
  always @(negedge clk) begin
    if (reset_n) begin
      prev_dout = rx_dout;
    end else begin
      if (rx_done_tick) begin
        strobes = strobes + 1;
        got_q.push_back(rx_dout);
      end
      if ((rx_dout !== prev_dout) && !rx_done_tick) bad_changes = bad_changes + 1;
      prev_dout = rx_dout;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int bound, output int t);
    int k;
    k = 0;
    t = -1;
    while (k < bound) begin
      step(1);
      k = k + 1;
      if (s_tick) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop);
    rx = 1'b0;
    step(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      step(BIT_CLK);
    end
    rx = stop;
    step(BIT_CLK);
    rx = 1'b1;
  endtask

  initial begin
    int t0, t1, t2, t3, ticks, base;
    logic [7:0] exp_b2b [4];
    exp_b2b[0] = 8'h00; exp_b2b[1] = 8'hFF; exp_b2b[2] = 8'h01; exp_b2b[3] = 8'h80;

    reset_n = 1'b1; rx = 1'b1; enable = 1'b0; final_value = 11'd650;
    step(3);
    check("rst_dout", {24'd0, rx_dout}, 32'h00);
    check("rst_done", {31'd0, rx_done_tick}, 32'd0);
    check("rst_tick", {31'd0, s_tick}, 32'd0);
    check("rst_state", 32'(dut.state_r), 32'd0);
    final_value = 11'd0; enable = 1'b1; #1;
    check("rst_tick_fv0", {31'd0, s_tick}, 32'd1);
    final_value = 11'd650; #1;
    step(1);
    reset_n = 1'b0;

    // Tick period with final_value = 650
    wait_tick(2000, t1);
    wait_tick(2000, t2);
    wait_tick(2000, t3);
    check("tick_period_1", 32'(t2 - t1), 32'd651);
    check("tick_period_2", 32'(t3 - t2), 32'd651);

    // final_value = 0: tick every cycle
    step(1);
    final_value = 11'd0; #1;
    check("fv0_tick_0", {31'd0, s_tick}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      step(1);
      check($sformatf("fv0_tick_%0d", i), {31'd0, s_tick}, 32'd1);
    end

    // enable = 0 freezes q and suppresses ticks
    enable = 1'b0; final_value = 11'd5; #1;
    check("dis_tick", {31'd0, s_tick}, 32'd0);
    enable = 1'b1;
    step(3);
    enable = 1'b0; #1;
    check("q_before_freeze", 32'(dut.q_r), 32'd3);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (s_tick) ticks = ticks + 1;
    end
    check("freeze_ticks", 32'(ticks), 32'd0);
    check("freeze_q", 32'(dut.q_r), 32'd3);

    // Lowering final_value below q forces a full wrap before the next tick
    enable = 1'b1; final_value = 11'd1; #1;
    t0 = cyc;
    wait_tick(3000, t1);
    check("wrap_delay", 32'(t1 - t0), 32'd2046);

    final_value = 11'd3;
    step(2 * BIT_CLK);

    // Single frame 0xA5
    base = strobes; got_q.delete();
    send_frame(8'hA5, 1'b1);
    check("a5_strobes", 32'(strobes - base), 32'd1);
    check("a5_value", {24'd0, (got_q.size() > 0) ? got_q[0] : 8'hXX}, 32'hA5);
    check("a5_dout", {24'd0, rx_dout}, 32'hA5);
    check("a5_idle", 32'(dut.state_r), 32'd0);

    // Back-to-back frames, no idle gap
    base = strobes; got_q.delete();
    for (int i = 0; i < 4; i++) send_frame(exp_b2b[i], 1'b1);
    step(BIT_CLK);
    check("b2b_strobes", 32'(strobes - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_value_%0d", i),
            {24'd0, (got_q.size() > i) ? got_q[i] : 8'hXX}, {24'd0, exp_b2b[i]});
    end

    // Start-bit glitch of 5 ticks is rejected, then 0x3C received
    base = strobes; got_q.delete();
    rx = 1'b0;
    step(5 * 4);
    rx = 1'b1;
    step(2 * BIT_CLK);
    check("glitch_strobes", 32'(strobes - base), 32'd0);
    check("glitch_idle", 32'(dut.state_r), 32'd0);
    send_frame(8'h3C, 1'b1);
    check("3c_strobes", 32'(strobes - base), 32'd1);
    check("3c_value", {24'd0, (got_q.size() > 0) ? got_q[0] : 8'hXX}, 32'h3C);

    // Stop bit driven low still delivers the byte
    step(BIT_CLK);
    base = strobes; got_q.delete();
    send_frame(8'h77, 1'b0);
    check("77_strobes", 32'(strobes - base), 32'd1);
    check("77_value", {24'd0, (got_q.size() > 0) ? got_q[0] : 8'hXX}, 32'h77);
    step(12 * BIT_CLK);

    // Reset in the middle of the 4th data bit
    base = strobes;
    rx = 1'b0;
    step(BIT_CLK);
    rx = 1'b1; step(BIT_CLK);
    rx = 1'b1; step(BIT_CLK);
    rx = 1'b0; step(BIT_CLK);
    rx = 1'b0; step(BIT_CLK / 2);
    reset_n = 1'b1; #1;
    check("midrst_dout", {24'd0, rx_dout}, 32'h00);
    check("midrst_done", {31'd0, rx_done_tick}, 32'd0);
    check("midrst_tick", {31'd0, s_tick}, 32'd0);
    check("midrst_state", 32'(dut.state_r), 32'd0);
    rx = 1'b1;
    step(3);
    reset_n = 1'b0;
    step(2 * BIT_CLK);
    check("midrst_no_strobe", 32'(strobes - base), 32'd0);
    got_q.delete();
    send_frame(8'h5A, 1'b1);
    check("5a_strobes", 32'(strobes - base), 32'd1);
    check("5a_dout", {24'd0, rx_dout}, 32'h5A);
    step(BIT_CLK);
    check("dout_stable", 32'(bad_changes), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
